bitop_rmw_engine: RTL and testbench

Parametrised read-modify-write bit-operation engine for the CPU test environment. It accepts a command (operation, bit index, address), then performs a bus read. It applies a CB-class bit, rotate or shift operation, writes the result back (except for BIT), and returns the result and flags on a response channel. It sits between the bench/test sequencer and the shared memory model, and drives the same active-low Z80-style strobes the core uses. Unlike the fixed 8-bit single-op check it replaces, it supports:
- a parametrised data width and address width;
- wait states;
- a wait-timeout error path.

---
 rtl/bitop_pkg.sv | 28 ++
 rtl/bitop_alu.sv | 38 +++
 rtl/bitop_rmw_engine.sv | 137 +++++++++++++
 tb/tb_bitop_rmw_engine.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitop_pkg.sv
// Shared types for the read-modify-write bit-operation engine:
// opcodes, flag bit positions and controller states.
package bitop_pkg;

  typedef enum logic [2:0] {
    OP_BIT = 3'd0,
    OP_RES = 3'd1,
    OP_SET = 3'd2,
    OP_RLC = 3'd3,
    OP_RRC = 3'd4,
    OP_SLA = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } bitop_op_e;

  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MOD  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } bitop_state_e;

endpackage

// File: rtl/bitop_alu.sv
// Combinational CB-class bit/rotate/shift unit producing result and {S,Z,C}.
module bitop_alu
  import bitop_pkg::*;
#(
  parameter int DW = 8
) (
  input  bitop_op_e           op,
  input  logic [$clog2(DW)-1:0] bit_sel,
  input  logic [DW-1:0]       data,
  output logic [DW-1:0]       result,
  output logic [2:0]          flags
);

  logic [DW-1:0] mask;
  logic          carry;

  always_comb begin
    mask   = {{(DW-1){1'b0}}, 1'b1} << bit_sel;
    result = data;
    carry  = 1'b0;
    case (op)
      OP_RES:  result = data & ~mask;
      OP_SET:  result = data | mask;
      OP_RLC:  begin result = {data[DW-2:0], data[DW-1]}; carry = data[DW-1]; end
      OP_RRC:  begin result = {data[0], data[DW-1:1]};    carry = data[0];    end
      OP_SLA:  begin result = {data[DW-2:0], 1'b0};       carry = data[DW-1]; end
      OP_SRL:  begin result = {1'b0, data[DW-1:1]};       carry = data[0];    end
      OP_SRA:  begin result = {data[DW-1], data[DW-1:1]}; carry = data[0];    end
      default: result = data;
    endcase
    flags         = 3'b000;
    flags[FLAG_S] = result[DW-1];
    // BIT reports the tested bit, not the (unchanged) result
    flags[FLAG_Z] = (op == OP_BIT) ? ~data[bit_sel] : (result == '0);
    flags[FLAG_C] = carry;
  end

endmodule

// File: rtl/bitop_rmw_engine.sv
// Read-modify-write bit-operation engine: command in, bus read, ALU op,
// bus write-back (skipped for BIT), response out, with wait-state timeout.
module bitop_rmw_engine
  import bitop_pkg::*;
#(
  parameter int DW         = 8,
  parameter int AW         = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [$clog2(DW)-1:0] cmd_bit,
  input  logic [AW-1:0]         cmd_addr,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_mreq_n,
  output logic                  mem_rd_n,
  output logic                  mem_wr_n,
  input  logic                  mem_wait_n,
  input  logic [DW-1:0]         mem_di,
  output logic [DW-1:0]         mem_do,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [2:0]            rsp_flags,
  output logic                  rsp_err
);

  localparam int BW = $clog2(DW);
  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  bitop_state_e    state_q, state_d;
  bitop_op_e       op_q;
  logic [BW-1:0]   bit_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q, res_q;
  logic [2:0]      flags_q;
  logic            err_q;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            mreq_n_q, rd_n_q, wr_n_q;
  logic            wait_hit;
  logic [DW-1:0]   alu_res;
  logic [2:0]      alu_flags;

  bitop_alu #(.DW(DW)) u_alu (
    .op      (op_q),
    .bit_sel (bit_q),
    .data    (data_q),
    .result  (alu_res),
    .flags   (alu_flags)
  );

  // Fires on the WAIT_LIMIT-th consecutive wait cycle of the current access
  assign wait_hit = (WAIT_LIMIT != 0) && !mem_wait_n &&
                    (int'(wcnt_q) == WAIT_LIMIT - 1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = RD;
      RD, WR: begin
        if (mem_wait_n)    state_d = (state_q == RD) ? MOD : RSP;
        else if (wait_hit) state_d = RSP;
        else               wcnt_d  = wcnt_q + 1'b1;
      end
      MOD:     state_d = (op_q == OP_BIT) ? RSP : WR;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) wcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_BIT;
      bit_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      mreq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      // strobes come straight from flops keyed on the next state
      mreq_n_q <= !(state_d == RD || state_d == WR);
      rd_n_q   <= (state_d != RD);
      wr_n_q   <= (state_d != WR);
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q   <= bitop_op_e'(cmd_op);
          bit_q  <= cmd_bit;
          addr_q <= cmd_addr;
        end
        RD: begin
          if (mem_wait_n) data_q <= mem_di;
          else if (wait_hit) begin
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b1;
          end
        end
        MOD: begin
          res_q   <= alu_res;
          flags_q <= alu_flags;
          err_q   <= 1'b0;
        end
        WR: if (wait_hit) begin
          res_q   <= '0;
          flags_q <= '0;
          err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RSP);
  assign mem_addr   = addr_q;
  assign mem_do     = res_q;
  assign mem_mreq_n = mreq_n_q;
  assign mem_rd_n   = rd_n_q;
  assign mem_wr_n   = wr_n_q;
  assign rsp_data   = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_bitop_rmw_engine.sv
// Bench for bitop_rmw_engine: an 8-bit instance (WAIT_LIMIT=3) and a 16-bit
// instance on a memory model with programmable wait states and a scoreboard.
`timescale 1ns/1ps
module tb_bitop_rmw_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_bit = '0;
  logic [15:0] cmd_addr = '0;
  logic        rsp_ready = 1'b0;

  logic        a_cmd_valid = 1'b0, a_cmd_ready, a_mreq_n, a_rd_n, a_wr_n, a_wait_n = 1'b1;
  logic        a_rsp_valid, a_rsp_err;
  logic [15:0] a_mem_addr;
  logic [7:0]  a_di, a_do, a_rsp_data;
  logic [2:0]  a_rsp_flags;

  logic        b_cmd_valid = 1'b0, b_cmd_ready, b_mreq_n, b_rd_n, b_wr_n, b_wait_n = 1'b1;
  logic        b_rsp_valid, b_rsp_err;
  logic [15:0] b_mem_addr;
  logic [15:0] b_di, b_do, b_rsp_data;
  logic [2:0]  b_rsp_flags;

  bitop_rmw_engine #(.DW(8), .AW(16), .WAIT_LIMIT(3)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(cmd_op), .cmd_bit(cmd_bit[2:0]), .cmd_addr(cmd_addr),
    .mem_addr(a_mem_addr), .mem_mreq_n(a_mreq_n), .mem_rd_n(a_rd_n), .mem_wr_n(a_wr_n),
    .mem_wait_n(a_wait_n), .mem_di(a_di), .mem_do(a_do),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
    .rsp_flags(a_rsp_flags), .rsp_err(a_rsp_err));

  bitop_rmw_engine #(.DW(16), .AW(16), .WAIT_LIMIT(15)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .cmd_bit(cmd_bit), .cmd_addr(cmd_addr),
    .mem_addr(b_mem_addr), .mem_mreq_n(b_mreq_n), .mem_rd_n(b_rd_n), .mem_wr_n(b_wr_n),
    .mem_wait_n(b_wait_n), .mem_di(b_di), .mem_do(b_do),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
    .rsp_flags(b_rsp_flags), .rsp_err(b_rsp_err));

  // Memory models; presets go through the same process that performs bus writes
  logic [7:0]  mem8  [0:65535];
  logic [15:0] mem16 [0:65535];
  logic        pre_en = 1'b0, pre_wide = 1'b0;
  logic [15:0] pre_addr = '0, pre_val = '0;
  int a_rd_waits = 0, a_wr_waits = 0, b_rd_waits = 0, b_wr_waits = 0;
  int a_cnt = 0, b_cnt = 0;

  assign a_di = mem8[a_mem_addr];
  assign b_di = mem16[b_mem_addr];

  always @(posedge clk) begin
    if (pre_en && !pre_wide) mem8[pre_addr] <= pre_val[7:0];
    else if (!a_mreq_n && !a_wr_n && a_wait_n) mem8[a_mem_addr] <= a_do;
  end

  always @(posedge clk) begin
    if (pre_en && pre_wide) mem16[pre_addr] <= pre_val;
    else if (!b_mreq_n && !b_wr_n && b_wait_n) mem16[b_mem_addr] <= b_do;
  end

  always @(negedge clk) begin
    if (!a_mreq_n && (!a_rd_n || !a_wr_n)) begin
      a_wait_n <= (a_cnt >= (!a_rd_n ? a_rd_waits : a_wr_waits));
      a_cnt    <= a_cnt + 1;
    end else begin
      a_wait_n <= 1'b1;
      a_cnt    <= 0;
    end
  end

  always @(negedge clk) begin
    if (!b_mreq_n && (!b_rd_n || !b_wr_n)) begin
      b_wait_n <= (b_cnt >= (!b_rd_n ? b_rd_waits : b_wr_waits));
      b_cnt    <= b_cnt + 1;
    end else begin
      b_wait_n <= 1'b1;
      b_cnt    <= 0;
    end
  end

  typedef struct {
    logic [15:0] data; logic [2:0] flags; logic err; int rsp_lat; int wr_first;
  } exp_t;
  typedef struct {
    logic [15:0] data; logic [2:0] flags; logic err; int rsp_lat; int wr_first;
    int wr_cnt; int rd_cnt; int overlap; int unstable; bit tmo;
  } obs_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic preset(input bit wide, input logic [15:0] addr, input logic [15:0] val);
    @(negedge clk);
    pre_wide = wide; pre_addr = addr; pre_val = val; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one command, watch the bus and collect the response (cycle numbers relative to accept)
  task automatic run_cmd(input bit wide, input logic [2:0] op, input logic [3:0] b,
                         input logic [15:0] addr, input int hold, output obs_t o);
    int n;
    bit got;
    logic wr_n, rd_n, vld;
    logic [19:0] snap;
    o = '{default: 0};
    o.wr_first = -1; o.rsp_lat = -1;
    @(negedge clk);
    cmd_op = op; cmd_bit = b; cmd_addr = addr;
    if (wide) b_cmd_valid = 1'b1; else a_cmd_valid = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      wr_n = wide ? b_wr_n : a_wr_n;
      rd_n = wide ? b_rd_n : a_rd_n;
      vld  = wide ? b_rsp_valid : a_rsp_valid;
      if (!wr_n) begin o.wr_cnt++; if (o.wr_first < 0) o.wr_first = cyc - n; end
      if (!rd_n) o.rd_cnt++;
      if (!rd_n && !wr_n) o.overlap++;
      if (vld) begin
        o.rsp_lat = cyc - n;
        o.data  = wide ? b_rsp_data : {8'h00, a_rsp_data};
        o.flags = wide ? b_rsp_flags : a_rsp_flags;
        o.err   = wide ? b_rsp_err : a_rsp_err;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          snap = wide ? {b_rsp_valid, b_rsp_data, b_rsp_flags}
                      : {a_rsp_valid, 8'h00, a_rsp_data, a_rsp_flags};
          if (snap != {1'b1, o.data, o.flags}) o.unstable++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        got = 1'b1;
      end
    end
    o.tmo = !got;
  endtask

  function automatic logic [10:0] ref8(input logic [2:0] op, input logic [2:0] b, input logic [7:0] d);
    logic [7:0] r;
    logic c, z;
    c = 1'b0;
    case (op)
      3'd0: r = d;
      3'd1: r = d & ~(8'd1 << b);
      3'd2: r = d | (8'd1 << b);
      3'd3: begin r = (d << 1) | (d >> 7); c = d[7]; end
      3'd4: begin r = (d >> 1) | (d << 7); c = d[0]; end
      3'd5: begin r = d << 1; c = d[7]; end
      3'd6: begin r = d >> 1; c = d[0]; end
      default: begin r = (d >> 1) | (d & 8'h80); c = d[0]; end
    endcase
    z = (op == 3'd0) ? !d[b] : (r == 8'h00);
    return {r, r[7], z, c};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_cmd_ready, a_mreq_n, a_rd_n, a_wr_n} !== 4'b1111) begin
      errors++; $display("FAIL reset_ctl8: got %b expected 1111", {a_cmd_ready, a_mreq_n, a_rd_n, a_wr_n});
    end
    checks++;
    if ({a_mem_addr, a_do} !== 24'h0) begin
      errors++; $display("FAIL reset_bus8: got addr=%h do=%h expected 0", a_mem_addr, a_do);
    end
    checks++;
    if ({a_rsp_valid, a_rsp_data, a_rsp_flags, a_rsp_err} !== 13'h0) begin
      errors++; $display("FAIL reset_rsp8: got v=%b d=%h f=%b e=%b expected 0", a_rsp_valid, a_rsp_data, a_rsp_flags, a_rsp_err);
    end
    checks++;
    if ({b_cmd_ready, b_mreq_n, b_rd_n, b_wr_n, b_rsp_valid, b_rsp_data, b_do} !== {4'b1111, 33'h0}) begin
      errors++; $display("FAIL reset_16: got ready=%b strobes=%b%b%b v=%b d=%h do=%h", b_cmd_ready, b_mreq_n, b_rd_n, b_wr_n, b_rsp_valid, b_rsp_data, b_do);
    end
  endtask

  task automatic test_set_res_bit();
    obs_t o; exp_t e;
    logic [2:0] ops [3] = '{3'd2, 3'd1, 3'd0};
    logic [3:0] bits[3] = '{4'd7, 4'd5, 4'd1};
    logic [7:0] mem_after[3] = '{8'hA1, 8'h01, 8'h01};
    sbq.push_back('{data: 16'h00A1, flags: 3'b100, err: 1'b0, rsp_lat: 4, wr_first: 3});
    sbq.push_back('{data: 16'h0001, flags: 3'b000, err: 1'b0, rsp_lat: 4, wr_first: 3});
    sbq.push_back('{data: 16'h0001, flags: 3'b010, err: 1'b0, rsp_lat: 3, wr_first: -1});
    for (int i = 0; i < 3; i++) begin
      if (i < 2) preset(1'b0, 16'h3324, 16'h0021);
      run_cmd(1'b0, ops[i], bits[i], 16'h3324, 0, o);
      e = sbq.pop_front();
      checks++;
      if (o.tmo || {o.data, o.flags, o.err} !== {e.data, e.flags, e.err}) begin
        errors++; $display("FAIL setresbit_rsp[%0d]: got d=%h f=%b e=%b tmo=%b expected d=%h f=%b e=%b", i, o.data, o.flags, o.err, o.tmo, e.data, e.flags, e.err);
      end
      checks++;
      if (o.rsp_lat != e.rsp_lat || o.wr_first != e.wr_first || o.overlap != 0) begin
        errors++; $display("FAIL setresbit_timing[%0d]: got rsp@%0d wr@%0d ovl=%0d expected rsp@%0d wr@%0d ovl=0", i, o.rsp_lat, o.wr_first, o.overlap, e.rsp_lat, e.wr_first);
      end
      checks++;
      if (mem8[16'h3324] !== mem_after[i]) begin
        errors++; $display("FAIL setresbit_mem[%0d]: got %h expected %h", i, mem8[16'h3324], mem_after[i]);
      end
    end
  endtask

  task automatic test_rotate_shift();
    obs_t o; exp_t e;
    preset(1'b0, 16'h1000, 16'h0080);
    preset(1'b0, 16'h1001, 16'h0001);
    a_rd_waits = 2;
    sbq.push_back('{data: 16'h0001, flags: 3'b001, err: 1'b0, rsp_lat: 6, wr_first: 5});
    run_cmd(1'b0, 3'd3, 4'd0, 16'h1000, 0, o);
    a_rd_waits = 0;
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err, mem8[16'h1000]} !== {e.data, e.flags, e.err, 8'h01}) begin
      errors++; $display("FAIL rlc_wait: got d=%h f=%b e=%b mem=%h expected d=%h f=%b e=%b mem=01", o.data, o.flags, o.err, mem8[16'h1000], e.data, e.flags, e.err);
    end
    checks++;
    if (o.rsp_lat != e.rsp_lat || o.wr_first != e.wr_first || o.rd_cnt != 3) begin
      errors++; $display("FAIL rlc_wait_timing: got rsp@%0d wr@%0d rd=%0d expected rsp@6 wr@5 rd=3", o.rsp_lat, o.wr_first, o.rd_cnt);
    end
    sbq.push_back('{data: 16'h0000, flags: 3'b011, err: 1'b0, rsp_lat: 4, wr_first: 3});
    run_cmd(1'b0, 3'd6, 4'd0, 16'h1001, 0, o);
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err, mem8[16'h1001]} !== {e.data, e.flags, e.err, 8'h00}) begin
      errors++; $display("FAIL srl: got d=%h f=%b e=%b mem=%h expected d=%h f=%b e=%b mem=00", o.data, o.flags, o.err, mem8[16'h1001], e.data, e.flags, e.err);
    end
  endtask

  task automatic test_wide();
    obs_t o; exp_t e;
    preset(1'b1, 16'h0200, 16'h8001);
    preset(1'b1, 16'h0202, 16'h0000);
    sbq.push_back('{data: 16'hC000, flags: 3'b101, err: 1'b0, rsp_lat: 4, wr_first: 3});
    run_cmd(1'b1, 3'd7, 4'd0, 16'h0200, 0, o);
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err, mem16[16'h0200]} !== {e.data, e.flags, e.err, 16'hC000}) begin
      errors++; $display("FAIL wide_sra: got d=%h f=%b e=%b mem=%h expected d=%h f=%b e=%b mem=c000", o.data, o.flags, o.err, mem16[16'h0200], e.data, e.flags, e.err);
    end
    sbq.push_back('{data: 16'h8000, flags: 3'b100, err: 1'b0, rsp_lat: 4, wr_first: 3});
    run_cmd(1'b1, 3'd2, 4'd15, 16'h0202, 0, o);
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err, mem16[16'h0202]} !== {e.data, e.flags, e.err, 16'h8000}) begin
      errors++; $display("FAIL wide_set15: got d=%h f=%b e=%b mem=%h expected d=%h f=%b e=%b mem=8000", o.data, o.flags, o.err, mem16[16'h0202], e.data, e.flags, e.err);
    end
    checks++;
    if (o.rsp_lat != e.rsp_lat || o.wr_first != e.wr_first) begin
      errors++; $display("FAIL wide_timing: got rsp@%0d wr@%0d expected rsp@4 wr@3", o.rsp_lat, o.wr_first);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    preset(1'b0, 16'h2000, 16'h00FF);
    a_rd_waits = 100;
    sbq.push_back('{data: 16'h0000, flags: 3'b000, err: 1'b1, rsp_lat: 4, wr_first: -1});
    run_cmd(1'b0, 3'd1, 4'd0, 16'h2000, 0, o);
    a_rd_waits = 0;
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err} !== {e.data, e.flags, e.err}) begin
      errors++; $display("FAIL rd_timeout_rsp: got d=%h f=%b e=%b expected d=0 f=0 e=1", o.data, o.flags, o.err);
    end
    checks++;
    if (o.rd_cnt != 3 || o.rsp_lat != 4 || o.wr_first != -1 || mem8[16'h2000] !== 8'hFF) begin
      errors++; $display("FAIL rd_timeout_bus: got rd=%0d rsp@%0d wr@%0d mem=%h expected rd=3 rsp@4 wr@-1 mem=ff", o.rd_cnt, o.rsp_lat, o.wr_first, mem8[16'h2000]);
    end
    preset(1'b0, 16'h2001, 16'h0000);
    a_wr_waits = 100;
    sbq.push_back('{data: 16'h0000, flags: 3'b000, err: 1'b1, rsp_lat: 6, wr_first: 3});
    run_cmd(1'b0, 3'd2, 4'd3, 16'h2001, 0, o);
    a_wr_waits = 0;
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err} !== {e.data, e.flags, e.err} || o.wr_cnt != 3 || o.rsp_lat != e.rsp_lat) begin
      errors++; $display("FAIL wr_timeout: got d=%h e=%b wr=%0d rsp@%0d expected d=0 e=1 wr=3 rsp@6", o.data, o.err, o.wr_cnt, o.rsp_lat);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    preset(1'b0, 16'h5000, 16'h005A);
    a_wr_waits = 100;
    @(negedge clk);
    cmd_op = 3'd2; cmd_bit = 4'd0; cmd_addr = 16'h5000; a_cmd_valid = 1'b1;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (a_wr_n && k < 20);
    checks++;
    if (a_wr_n !== 1'b0) begin
      errors++; $display("FAIL reset_mid_reach_wr: got wr_n=%b expected 0", a_wr_n);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    a_wr_waits = 0;
    @(negedge clk);
    checks++;
    if ({a_mreq_n, a_rd_n, a_wr_n, a_cmd_ready, a_rsp_valid} !== 5'b11110) begin
      errors++; $display("FAIL reset_mid_state: got strobes=%b%b%b ready=%b valid=%b expected 111 1 0", a_mreq_n, a_rd_n, a_wr_n, a_cmd_ready, a_rsp_valid);
    end
    checks++;
    if (mem8[16'h5000] !== 8'h5A) begin
      errors++; $display("FAIL reset_mid_mem: got %h expected 5a", mem8[16'h5000]);
    end
  endtask

  task automatic test_hold();
    obs_t o; exp_t e;
    preset(1'b0, 16'h6000, 16'h0010);
    sbq.push_back('{data: 16'h0011, flags: 3'b000, err: 1'b0, rsp_lat: 4, wr_first: 3});
    run_cmd(1'b0, 3'd2, 4'd0, 16'h6000, 5, o);
    e = sbq.pop_front();
    checks++;
    if (o.tmo || {o.data, o.flags, o.err} !== {e.data, e.flags, e.err} || o.unstable != 0) begin
      errors++; $display("FAIL hold_rsp: got d=%h f=%b e=%b unstable=%0d expected d=%h f=%b e=0 unstable=0", o.data, o.flags, o.err, o.unstable, e.data, e.flags);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic [2:0] op, b;
    logic [7:0] d;
    logic [10:0] r;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      a_rd_waits = $urandom_range(0, 2);
      a_wr_waits = $urandom_range(0, 2);
      preset(1'b0, 16'h4000 + 16'(i), {8'h00, d});
      r = ref8(op, b, d);
      sbq.push_back('{data: {8'h00, r[10:3]}, flags: r[2:0], err: 1'b0,
                      rsp_lat: (op == 3'd0) ? a_rd_waits + 3 : a_rd_waits + a_wr_waits + 4,
                      wr_first: (op == 3'd0) ? -1 : a_rd_waits + 3});
      run_cmd(1'b0, op, {1'b0, b}, 16'h4000 + 16'(i), 0, o);
      e = sbq.pop_front();
      checks++;
      if (o.tmo || {o.data, o.flags, o.err} !== {e.data, e.flags, e.err} ||
          o.rsp_lat != e.rsp_lat || o.wr_first != e.wr_first || o.overlap != 0 ||
          mem8[16'h4000 + 16'(i)] !== e.data[7:0]) begin
        errors++; $display("FAIL b2b[%0d] op=%0d bit=%0d din=%h: got d=%h f=%b rsp@%0d wr@%0d mem=%h expected d=%h f=%b rsp@%0d wr@%0d",
          i, op, b, d, o.data, o.flags, o.rsp_lat, o.wr_first, mem8[16'h4000 + 16'(i)], e.data, e.flags, e.rsp_lat, e.wr_first);
      end
    end
    a_rd_waits = 0; a_wr_waits = 0;
  endtask

  initial begin
    test_reset();
    test_set_res_bit();
    test_rotate_shift();
    test_wide();
    test_timeout();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
